// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: FSM states and PC-register select encodings.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [1:0] kPCSelNone = 2'b00;
  localparam logic [1:0] kPCSel1    = 2'b01;
  localparam logic [1:0] kPCSel2    = 2'b10;
  localparam logic [1:0] kPCSel3    = 2'b11;

endpackage

// File: rtl/fetch_unit_pc_target_regs.sv
// Three saved jump-target registers (PCreg1-3): one write port, one combinational read port.
module pc_target_regs
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [1:0]      wr_sel_i,
  input  logic [PC_W-1:0] wr_data_i,
  input  logic [1:0]      rd_sel_i,
  output logic [PC_W-1:0] rd_data_o
);

  logic [PC_W-1:0] reg1_q, reg2_q, reg3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg1_q <= '0;
      reg2_q <= '0;
      reg3_q <= '0;
    end else if (wr_en_i) begin
      case (wr_sel_i)
        kPCSel1: reg1_q <= wr_data_i;
        kPCSel2: reg2_q <= wr_data_i;
        kPCSel3: reg3_q <= wr_data_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (rd_sel_i)
      kPCSel1: rd_data_o = reg1_q;
      kPCSel2: rd_data_o = reg2_q;
      kPCSel3: rd_data_o = reg3_q;
      default: rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer with Start/Done handshake and saved jump targets.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating 16-bit RUN-cycle counter output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int OFF_W      = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            JumpEqual,
  input  logic            JumpNotEqual,
  input  logic            OffsetEn,
  input  logic [1:0]      PCRegSelect,
  input  logic            Ack,
  input  logic [7:0]      RegDataB,
  input  logic            FlagWrEn,
  input  logic            ZeroIn,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Done
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]     CycleCount
`endif
);

  localparam logic [PC_W-1:0] kStartPc = PC_W'(START_ADDR);

  // Signed offset is sign-extended to PC width; the sum wraps modulo 2**PC_W.
  function automatic logic [PC_W-1:0] offset_target(input logic [PC_W-1:0] pc,
                                                    input logic signed [OFF_W-1:0] off);
    logic signed [PC_W-1:0] ext;
    ext = PC_W'(off);
    return pc + PC_W'(ext);
  endfunction

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic            done_q;
  logic            zflag_q;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] pc_next_d;
  logic [PC_W-1:0] save_data_d;
  logic            jump_taken;
  logic            save_en;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]     cnt_q;
`endif

  assign pc_plus1   = pc_q + PC_W'(1);
  assign jump_taken = (PCRegSelect != kPCSelNone) &&
                      ((JumpEqual && zflag_q) || (JumpNotEqual && !zflag_q));
  assign save_en    = (state_q == RUN) && !Start && !Ack &&
                      (PCRegSelect != kPCSelNone) && !JumpEqual && !JumpNotEqual;
  assign save_data_d = OffsetEn ? offset_target(pc_q, RegDataB[OFF_W-1:0]) : pc_plus1;
  assign pc_next_d   = jump_taken ? target : pc_plus1;

  pc_target_regs #(.PC_W(PC_W)) u_pc_regs (
    .clk_i    (Clk),
    .rst_ni   (Reset),
    .wr_en_i  (save_en),
    .wr_sel_i (PCRegSelect),
    .wr_data_i(save_data_d),
    .rd_sel_i (PCRegSelect),
    .rd_data_o(target)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= kStartPc;
      done_q  <= 1'b0;
      zflag_q <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          pc_q    <= kStartPc;
          done_q  <= 1'b0;
          zflag_q <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
          cnt_q   <= '0;
`endif
          if (!Start) state_q <= RUN;
        end
        RUN: begin
          // A jump in this cycle already used the old zflag_q above.
          if (FlagWrEn) zflag_q <= ZeroIn;
`ifdef FETCH_CYCLE_COUNT_EN
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
`endif
          if (Start) begin
            state_q <= IDLE;
            pc_q    <= kStartPc;
`ifdef FETCH_CYCLE_COUNT_EN
            cnt_q   <= '0;
`endif
          end else if (Ack) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            pc_q <= pc_next_d;
          end
        end
        DONE: begin
          if (Start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            pc_q    <= kStartPc;
`ifdef FETCH_CYCLE_COUNT_EN
            cnt_q   <= '0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          pc_q    <= kStartPc;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr = pc_q;
  assign Done    = done_q;
`ifdef FETCH_CYCLE_COUNT_EN
  assign CycleCount = cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch sequencer that drives the instruction ROM address; sits directly upstream of the control decoder.
- Consumes the decoder's jump/save controls (JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect, Ack), holds three saved target registers (PCreg1-3) and a registered zero flag.
- Runs the Start/Done program handshake with the test harness.

Parameters:
- PC_W, 10, program-counter width; instruction ROM depth is 2**PC_W.
- START_ADDR, 0, PC value loaded on reset and while Start is high.
- OFF_W, 8, width of the signed offset taken from register-file read port B (r8).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  harness start request; level-sensitive.
- JumpEqual  input  1  je decoded.
- JumpNotEqual  input  1  jne decoded.
- OffsetEn  input  1  spc saves with offset.
- PCRegSelect  input  2  00 none, 01/10/11 select PCreg1/2/3.
- Ack  input  1  decoder's end-of-program (all-ones instruction).
- RegDataB  input  8  register-file port B data (r8 during spc); low OFF_W bits are a signed offset.
- FlagWrEn  input  1  current instruction updates the zero flag.
- ZeroIn  input  1  ALU zero result, combinational.
- ProgCtr  output  PC_W  instruction ROM address.
- Done  output  1  program finished.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset asserted (Reset=0), asynchronously:
  - state=IDLE, ProgCtr=START_ADDR, PCreg1-3=0, ZeroFlag=0, Done=0.
- IDLE:
  - ProgCtr held at START_ADDR; ZeroFlag cleared.
  - When Start=0 at a rising edge, state becomes RUN. The first RUN cycle fetches START_ADDR.
- RUN, one instruction per cycle, priority in this order:
  1. Start=1: go to IDLE and set ProgCtr=START_ADDR. PCreg contents are kept.
  2. Ack=1: go to DONE and hold ProgCtr. Any simultaneous jump or save is ignored.
  3. Jump taken: ProgCtr <= PCreg[PCRegSelect].
     - je is taken when JumpEqual=1 and ZeroFlag=1.
     - jne is taken when JumpNotEqual=1 and ZeroFlag=0.
     - PCRegSelect=00 never jumps.
  4. Otherwise: ProgCtr <= ProgCtr+1, modulo 2**PC_W. Max value wraps to 0.
- Save (spc): fires when PCRegSelect!=00 and neither jump input is set.
  - PCreg[sel] <= OffsetEn ? ProgCtr + sext(RegDataB[OFF_W-1:0]) : ProgCtr + 1.
  - Sum is modulo 2**PC_W.
  - The PC still advances by 1 in the same cycle.
- Zero flag:
  - ZeroFlag <= ZeroIn at the edge where FlagWrEn=1 in RUN.
  - A je/jne in the same cycle as FlagWrEn uses the old registered flag.
- DONE:
  - Done=1 and ProgCtr held.
  - Start=1 moves to IDLE, clears Done and reloads START_ADDR.
- Done is registered and is high only in DONE.
- Latency:
  - ProgCtr changes one edge after the decoded instruction.
  - A taken jump's target is fetched in the next cycle; there are no delay slots.

Optional Feature:
- Macro FETCH_CYCLE_COUNT_EN.
- When defined:
  - Adds output CycleCount, 16 bits.
  - Cleared on reset and in IDLE.
  - Increments every RUN cycle, saturating at 16'hFFFF.
  - Frozen in DONE.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package definitions holds:
  - the fetch_state_t enum {IDLE, RUN, DONE};
  - the PCRegSelect encodings (kPCSelNone, kPCSel1..3).
- One sub-module, pc_target_regs:
  - 3-entry PC_W-bit register file with async active-low reset;
  - one write port (sel, data, en) and one combinational read port.

Test Plan:
1. Reset=0 mid-RUN with ProgCtr=37 -> ProgCtr=0, Done=0 immediately; after release with Start=1 then Start=0, fetches 0,1,2,...
2. spc at ProgCtr=10, PCRegSelect=01, OffsetEn=1, RegDataB=8'hFC -> PCreg1=6, next ProgCtr=11; later je with ZeroFlag=1, PCRegSelect=01 -> next ProgCtr=6.
3. jne with PCRegSelect=10 while FlagWrEn=1, ZeroIn=1 and old ZeroFlag=0 -> jump taken (old flag used); a following jne at the same PC falls through.
4. je with PCRegSelect=00 and ZeroFlag=1 -> ProgCtr+1; ProgCtr=1023 (PC_W=10) advancing -> 0.
5. Ack=1 together with JumpEqual=1 at ProgCtr=50 -> DONE, Done=1, ProgCtr stays 50; Start=1 -> IDLE, Done=0, ProgCtr=0.
6. With FETCH_CYCLE_COUNT_EN: run 20 cycles, then Ack -> CycleCount=20 and holds in DONE; Start clears it to 0.
